// File: rtl/wshb_burst_reader.sv
// Wishbone read master that streams a frame of NWORDS words from memory in
// fixed-length bursts into a show-ahead FIFO, presented as a valid/ready
// pixel stream with a frame_start tag on word 0.
module wshb_burst_reader #(
   parameter int unsigned WIDTH      = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int unsigned NWORDS     = 1024,
   parameter int unsigned BURST      = 8,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   // Wishbone master
   output logic               wshb_cyc_o,
   output logic               wshb_stb_o,
   output logic               wshb_we_o,
   output logic [31:0]        wshb_adr_o,
   output logic [WIDTH/8-1:0] wshb_sel_o,
   output logic [WIDTH-1:0]   wshb_dat_ms_o,
   input  logic [WIDTH-1:0]   wshb_dat_sm_i,
   input  logic               wshb_ack_i,
   input  logic               wshb_err_i,
   input  logic               wshb_rty_i,
   // Control and pixel stream
   input  logic               enable_i,
   output logic [WIDTH-1:0]   pix_data_o,
   output logic               pix_valid_o,
   input  logic               pix_ready_i,
   output logic               frame_start_o
);

   localparam int unsigned IdxW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned BeatW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned Step  = WIDTH / 8;

   localparam logic [CntW-1:0]  DepthC   = CntW'(FIFO_DEPTH);
   localparam logic [CntW-1:0]  BurstC   = CntW'(BURST);
   localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NWORDS - 1);
   localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST - 1);

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  word_idx_q, word_idx_d;
   logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
   logic [31:0]      adr_q, adr_d;

   // FIFO storage: MSB carries the frame_start tag
   logic [WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   logic             push;
   logic             pop;
   logic             flush;
   logic             beat_fail;
   logic [CntW-1:0]  credit;
   logic [CntW-1:0]  credit_next;

   // Per-cycle FIFO and bus event decode
   always_comb begin
      beat_fail   = wshb_err_i | wshb_rty_i;
      push        = (state_q == StBurst) && wshb_ack_i && !beat_fail;
      pop         = pix_valid_o && pix_ready_i;
      flush       = (state_q == StIdle) && !enable_i;
      credit      = DepthC - count_q;
      credit_next = DepthC - count_d;
   end

   // FIFO pointer and occupancy next-state; flush overrides push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Burst FSM: next state, word/beat counters and bus strobe
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      beat_cnt_d = beat_cnt_q;
      wshb_cyc_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (!enable_i) begin
               word_idx_d = '0;
            end else if (credit >= BurstC) begin
               state_d    = StBurst;
               beat_cnt_d = '0;
            end
         end
         StBurst: begin
            wshb_cyc_o = 1'b1;
            if (beat_fail) begin
               // Failed beat: retry the same word later with a fresh burst
               state_d    = StIdle;
               beat_cnt_d = '0;
            end else if (wshb_ack_i) begin
               word_idx_d = (word_idx_q == LastIdx) ? '0 : word_idx_q + 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LastBeat) begin
                  beat_cnt_d = '0;
                  // Chain straight into the next burst only if it is sure to fit
                  if (!(enable_i && (credit_next >= BurstC))) begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Address tracks the word index so it is stable until the beat is acked
   always_comb begin
      adr_d = BASE_ADDR + (32'(word_idx_d) * 32'(Step));
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         word_idx_q <= '0;
         beat_cnt_q <= '0;
         adr_q      <= BASE_ADDR;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         beat_cnt_q <= beat_cnt_d;
         adr_q      <= adr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage write; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {(word_idx_q == '0), wshb_dat_sm_i};
      end
   end

   // Output assignments
   always_comb begin
      wshb_stb_o    = wshb_cyc_o;
      wshb_we_o     = 1'b0;
      wshb_sel_o    = '1;
      wshb_dat_ms_o = '0;
      wshb_adr_o    = adr_q;
      pix_valid_o   = (count_q != '0);
      pix_data_o    = fifo_mem[rd_ptr_q][WIDTH-1:0];
      frame_start_o = pix_valid_o && fifo_mem[rd_ptr_q][WIDTH];
   end

endmodule
